// File: rtl/stdp_update_sched.sv
// STDP pairing detector with one pending LTP/LTD slot per synapse and a
// round-robin scheduler that offers updates over a valid/ready handshake.
module stdp_syn_lane #(
  parameter int TW  = 4,
  parameter int WIN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          pre,
  input  logic          post,
  input  logic          post_recent,
  input  logic [TW-1:0] post_age,
  input  logic          clr_ltp,
  input  logic          clr_ltd,
  output logic          ltp_ev,
  output logic          ltd_ev,
  output logic          ltp_pend,
  output logic          ltd_pend,
  output logic          ovf_hit,
  output logic [TW-1:0] ltp_dt,
  output logic [TW-1:0] ltd_dt
);
  logic [TW-1:0] pre_age;
  logic          pre_recent;

  assign pre_recent = pre_age < TW'(WIN);
  // a coincident pre only yields a dt=0 LTP when no older pre is still in window
  assign ltp_ev  = post & (pre_recent | pre);
  assign ltd_ev  = pre & ~post & post_recent;
  assign ovf_hit = (ltp_ev & ltp_pend) | (ltd_ev & ltd_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_age  <= TW'(WIN);
      ltp_pend <= 1'b0;
      ltd_pend <= 1'b0;
      ltp_dt   <= '0;
      ltd_dt   <= '0;
    end else begin
      if (pre)                     pre_age <= '0;
      else if (tick && pre_recent) pre_age <= pre_age + TW'(1);
      if (ltp_ev) begin
        ltp_pend <= 1'b1;
        ltp_dt   <= pre_recent ? pre_age : '0;
      end else if (clr_ltp) ltp_pend <= 1'b0;
      if (ltd_ev) begin
        ltd_pend <= 1'b1;
        ltd_dt   <= post_age;
      end else if (clr_ltd) ltd_pend <= 1'b0;
    end
  end
endmodule

module stdp_update_sched #(
  parameter  int N_SYN = 4,
  parameter  int TW    = 4,
  parameter  int WIN   = 8,
  localparam int IW    = $clog2(N_SYN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_SYN-1:0] pre_spike,
  input  logic             post_spike,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IW-1:0]    upd_idx,
  output logic             upd_ltp,
  output logic [TW-1:0]    upd_dt,
  output logic             busy,
  output logic             overflow,
  input  logic             clear_ovf
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, nxt;

  logic [N_SYN-1:0]         ltp_ev, ltd_ev, ltp_pend, ltd_pend, ovf_hit, clr_ltp, clr_ltd, pend_any;
  logic [N_SYN-1:0][TW-1:0] ltp_dt, ltd_dt;
  logic [TW-1:0]            post_age;
  logic                     post_recent, sel_found, load, hs, hit, redo, do_clr;
  logic [IW-1:0]            rr_ptr, sel_idx;
  logic [IW:0]              j_w;

  assign post_recent = post_age < TW'(WIN);
  assign pend_any    = ltp_pend | ltd_pend;

  for (genvar g = 0; g < N_SYN; g++) begin : g_lane
    stdp_syn_lane #(.TW(TW), .WIN(WIN)) u_lane (
      .clk(clk), .rst_n(rst_n), .tick(tick), .pre(pre_spike[g]), .post(post_spike),
      .post_recent(post_recent), .post_age(post_age),
      .clr_ltp(clr_ltp[g]), .clr_ltd(clr_ltd[g]),
      .ltp_ev(ltp_ev[g]), .ltd_ev(ltd_ev[g]), .ltp_pend(ltp_pend[g]), .ltd_pend(ltd_pend[g]),
      .ovf_hit(ovf_hit[g]), .ltp_dt(ltp_dt[g]), .ltd_dt(ltd_dt[g])
    );
  end

  // wrap-around scan starting at rr_ptr
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    j_w       = '0;
    for (int k = 0; k < N_SYN; k++) begin
      j_w = (IW+1)'(rr_ptr) + (IW+1)'(k);
      if (j_w >= (IW+1)'(N_SYN)) j_w = j_w - (IW+1)'(N_SYN);
      if (!sel_found && pend_any[j_w[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = j_w[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (sel_found) nxt = OFFER;
      OFFER:   if (upd_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    upd_valid = (state == OFFER);
    load      = (state == IDLE) && sel_found;
    hs        = (state == OFFER) && upd_ready;
  end

  // an event landing on the offered slot during the offer keeps it pending for a re-offer
  assign hit     = upd_ltp ? ltp_ev[upd_idx] : ltd_ev[upd_idx];
  assign do_clr  = hs & ~redo & ~hit;
  assign clr_ltp = (do_clr &  upd_ltp) ? (N_SYN'(1) << upd_idx) : '0;
  assign clr_ltd = (do_clr & ~upd_ltp) ? (N_SYN'(1) << upd_idx) : '0;
  assign busy    = (|pend_any) | (state == OFFER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_age <= TW'(WIN);
      rr_ptr   <= '0;
      upd_idx  <= '0;
      upd_ltp  <= 1'b0;
      upd_dt   <= '0;
      redo     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (post_spike)               post_age <= '0;
      else if (tick && post_recent) post_age <= post_age + TW'(1);
      if (load) begin
        upd_idx <= sel_idx;
        upd_ltp <= ltp_pend[sel_idx];
        upd_dt  <= ltp_pend[sel_idx] ? ltp_dt[sel_idx] : ltd_dt[sel_idx];
      end
      if (hs) begin
        rr_ptr <= (upd_idx == IW'(N_SYN-1)) ? '0 : upd_idx + IW'(1);
        redo   <= 1'b0;
      end else if ((state == OFFER) && hit) redo <= 1'b1;
      if (|ovf_hit)       overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stdp_update_sched.sv
// Scoreboard bench for stdp_update_sched: directed pairing scenarios plus
// randomized spike/ready traffic against an event-level reference model.
module tb_stdp_update_sched;
  localparam int N = 4, TW = 4, WIN = 8;

  logic          clk = 1'b0, rst_n = 1'b0, tick = 1'b0, post_spike = 1'b0;
  logic          upd_ready = 1'b0, clear_ovf = 1'b0;
  logic [N-1:0]  pre_spike = '0;
  logic          upd_valid, upd_ltp, busy, overflow;
  logic [1:0]    upd_idx;
  logic [TW-1:0] upd_dt;

  stdp_update_sched #(.N_SYN(N), .TW(TW), .WIN(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pre_spike(pre_spike), .post_spike(post_spike),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_ltp(upd_ltp),
    .upd_dt(upd_dt), .busy(busy), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {int idx; bit ltp; int dt;} req_t;
  req_t expq[$];

  // reference model: ages in ticks, one pending slot per synapse/type, current offer
  int m_pre[N], m_post, m_tdt[N], m_ddt[N], m_rr, m_oidx;
  bit m_lp[N], m_ld[N], m_off, m_oltp, m_refr, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pre[i] = WIN; m_lp[i] = 0; m_ld[i] = 0; m_tdt[i] = 0; m_ddt[i] = 0;
    end
    m_post = WIN; m_rr = 0; m_off = 0; m_oltp = 0; m_oidx = 0; m_refr = 0; m_ovf = 0;
    expq.delete();
  endtask

  task automatic model_step();
    bit evp[N], evd[N], hit, ovs;
    int dtp[N];
    req_t r;
    for (int i = 0; i < N; i++) begin
      evp[i] = post_spike && (m_pre[i] < WIN || pre_spike[i]);
      dtp[i] = (m_pre[i] < WIN) ? m_pre[i] : 0;
      evd[i] = pre_spike[i] && !post_spike && (m_post < WIN);
    end
    if (m_off) begin
      hit = m_oltp ? evp[m_oidx] : evd[m_oidx];
      if (upd_ready) begin
        if (!m_refr && !hit) begin
          if (m_oltp) m_lp[m_oidx] = 0; else m_ld[m_oidx] = 0;
        end
        m_rr = (m_oidx + 1) % N; m_off = 0; m_refr = 0;
      end else if (hit) m_refr = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!m_off && (m_lp[j] || m_ld[j])) begin
          m_off = 1; m_oidx = j; m_oltp = m_lp[j];
          r.idx = j; r.ltp = m_lp[j]; r.dt = m_lp[j] ? m_tdt[j] : m_ddt[j];
          expq.push_back(r);
        end
      end
    end
    ovs = 0;
    for (int i = 0; i < N; i++) begin
      if (evp[i]) begin ovs |= m_lp[i]; m_lp[i] = 1; m_tdt[i] = dtp[i]; end
      if (evd[i]) begin ovs |= m_ld[i]; m_ld[i] = 1; m_ddt[i] = m_post; end
    end
    if (ovs) m_ovf = 1; else if (clear_ovf) m_ovf = 0;
    for (int i = 0; i < N; i++)
      if (pre_spike[i]) m_pre[i] = 0; else if (tick && m_pre[i] < WIN) m_pre[i]++;
    if (post_spike) m_post = 0; else if (tick && m_post < WIN) m_post++;
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_off;
    for (int i = 0; i < N; i++) b |= m_lp[i] | m_ld[i];
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // monitor: pops the expected request on each handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", upd_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_idx", upd_idx, 0);
      check("rst_dt", upd_dt, 0);
    end else begin
      check("valid", upd_valid, m_off);
      check("busy", busy, model_busy());
      check("overflow", overflow, m_ovf);
      if (upd_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual idx %0d expected none", upd_idx);
        end else begin
          check("req_idx", upd_idx, expq[0].idx);
          check("req_ltp", upd_ltp, expq[0].ltp);
          check("req_dt", upd_dt, expq[0].dt);
          if (upd_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit tk, input logic [N-1:0] pr, input bit po, input bit rdy, input bit clr);
    tick = tk; pre_spike = pr; post_spike = po; upd_ready = rdy; clear_ovf = clr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, '0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_offer(input int ei, input int el, input int ed, input int hold);
    int n = 0;
    while (!upd_valid && n < 20) begin cyc(0, '0, 0, 0, 0); n++; end
    if (!upd_valid) begin
      checks++; errors++;
      $display("FAIL offer_timeout actual none expected idx %0d", ei);
      return;
    end
    check("offer_idx", upd_idx, ei);
    check("offer_ltp", upd_ltp, el);
    check("offer_dt", upd_dt, ed);
    repeat (hold) begin
      cyc(0, '0, 0, 0, 0);
      check("hold_valid", upd_valid, 1);
      check("hold_idx", upd_idx, ei);
      check("hold_dt", upd_dt, ed);
    end
    cyc(0, '0, 0, 1, 0);
    check("after_hs_valid", upd_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    // T1: post with no prior pre
    do_reset();
    cyc(0, '0, 1, 0, 0);
    repeat (3) begin
      cyc(0, '0, 0, 0, 0);
      check("t1_valid", upd_valid, 0);
      check("t1_busy", busy, 0);
      check("t1_ovf", overflow, 0);
    end
    // T2: LTP dt=3 held under backpressure
    do_reset();
    cyc(0, 4'b0100, 0, 0, 0);
    repeat (3) cyc(1, '0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    wait_offer(2, 1, 3, 5);
    // T3: LTD dt=2
    do_reset();
    cyc(0, '0, 1, 0, 0);
    repeat (2) cyc(1, '0, 0, 0, 0);
    cyc(0, 4'b0010, 0, 0, 0);
    wait_offer(1, 0, 2, 0);
    // T4: round-robin order and pointer wrap
    do_reset();
    cyc(0, 4'b1001, 0, 0, 0);
    cyc(1, '0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    wait_offer(0, 1, 1, 0);
    wait_offer(3, 1, 1, 0);
    repeat (9) cyc(1, '0, 0, 0, 0);
    check("t4_idle_busy", busy, 0);
    cyc(0, 4'b1001, 0, 0, 0);
    cyc(1, '0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    wait_offer(0, 1, 1, 0);
    wait_offer(3, 1, 1, 0);
    // T5: pre aged out to WIN
    do_reset();
    cyc(0, 4'b0010, 0, 0, 0);
    repeat (8) cyc(1, '0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    repeat (4) begin
      cyc(0, '0, 0, 0, 0);
      check("t5_valid", upd_valid, 0);
      check("t5_busy", busy, 0);
    end
    // T6: overwrite during offer, re-offer with new dt, overflow clear
    do_reset();
    cyc(0, 4'b0100, 0, 0, 0);
    cyc(1, '0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(1, '0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    check("t6_ovf_set", overflow, 1);
    wait_offer(2, 1, 1, 0);
    wait_offer(2, 1, 2, 0);
    check("t6_ovf_hold", overflow, 1);
    cyc(0, '0, 0, 0, 1);
    check("t6_ovf_clr", overflow, 0);
    // randomized traffic, checked by the monitor
    do_reset();
    repeat (3000) begin
      logic [N-1:0] pr;
      for (int i = 0; i < N; i++) pr[i] = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 2) == 0, pr, $urandom_range(0, 9) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end
    repeat (30) cyc(0, '0, 0, 1, 0);
    check("drain_queue", expq.size(), 0);
    check("drain_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
